// File: rtl/parking_sensor_encoder_if.sv
// Sensor inputs and command/ack bundle between the encoder
// and the parking-state FSM.
interface parking_sensor_encoder_if;
  logic       enter_raw;
  logic [3:0] leave_raw;
  logic       door_open_pulse;
  logic [3:0] cmd;
  logic       busy;
  logic       drop_err;
  logic [4:0] pending;

  modport master (
    input  enter_raw,
    input  leave_raw,
    input  door_open_pulse,
    output cmd,
    output busy,
    output drop_err,
    output pending
  );

  modport slave (
    output enter_raw,
    output leave_raw,
    output door_open_pulse,
    input  cmd,
    input  busy,
    input  drop_err,
    input  pending
  );
endinterface

// File: rtl/parking_sensor_encoder.sv
// Debounces gate/spot sensors and issues one-cycle commands with ack timeout.
// Optional: define PARKING_ENC_RETRY_EN to reissue a command once on timeout.
module parking_sensor_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 8
) (
  input logic clk,
  input logic reset,
  parking_sensor_encoder_if.master bus
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK
  } state_t;

  state_t state, state_nx;

  logic [4:0]      raw;
  logic [4:0]      deb;
  logic [4:0]      deb_q;
  logic [4:0]      rise;
  logic [4:0][7:0] db_cnt;

  logic [4:0] pending;
  logic       sel_enter;
  logic [1:0] sel_spot;
  logic       exit_next;
  logic [7:0] to_cnt;
  logic       drop_q;

  logic       exit_pend;
  logic       pick_enter;
  logic [1:0] pick_spot;
  logic       served_done;
  logic       drop;
  logic       retry_ok;
  logic [4:0] served_mask;
  logic [4:0] clr;

  assign raw  = {bus.enter_raw, bus.leave_raw};
  assign rise = deb & ~deb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb    <= '0;
      deb_q  <= '0;
      db_cnt <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < 5; i++) begin
        if (raw[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= raw[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Exits and enter alternate only when both classes are waiting.
  assign exit_pend  = |pending[3:0];
  assign pick_enter = pending[4] & (~exit_pend | ~exit_next);

  always_comb begin
    pick_spot = 2'd0;
    unique casez (pending[3:0])
      4'b???1: pick_spot = 2'd0;
      4'b??10: pick_spot = 2'd1;
      4'b?100: pick_spot = 2'd2;
      4'b1000: pick_spot = 2'd3;
      default: pick_spot = 2'd0;
    endcase
  end

`ifdef PARKING_ENC_RETRY_EN
  logic retried;
  assign retry_ok = ~retried;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retried <= 1'b0;
    end else if (state == IDLE) begin
      retried <= 1'b0;
    end else if (state == WAIT_ACK && state_nx == ISSUE) begin
      retried <= 1'b1;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    served_done = 1'b0;
    drop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pending) state_nx = ISSUE;
      end
      ISSUE: begin
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.door_open_pulse) begin
          state_nx    = IDLE;
          served_done = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          if (retry_ok) begin
            state_nx = ISSUE;
          end else begin
            state_nx    = IDLE;
            served_done = 1'b1;
            drop        = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign served_mask = sel_enter ? 5'b10000
                                 : {1'b0, 4'b0001 << sel_spot};
  assign clr = served_done ? served_mask : 5'b00000;

  // Set beats clear: a fresh edge on the served input survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      sel_enter <= 1'b0;
      sel_spot  <= 2'd0;
      exit_next <= 1'b1;
      to_cnt    <= '0;
      drop_q    <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | rise;
      drop_q  <= drop;
      if (state == IDLE && |pending) begin
        sel_enter <= pick_enter;
        sel_spot  <= pick_spot;
        exit_next <= pick_enter;
      end
      if (state == WAIT_ACK) begin
        to_cnt <= to_cnt + 8'd1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

  always_comb begin
    bus.cmd  = 4'b0000;
    bus.busy = 1'b0;
    unique case (state)
      ISSUE: begin
        bus.cmd  = sel_enter ? 4'b1000 : {2'b01, sel_spot};
        bus.busy = 1'b1;
      end
      WAIT_ACK: bus.busy = 1'b1;
      default: ;
    endcase
  end

  assign bus.pending  = pending;
  assign bus.drop_err = drop_q;

endmodule

// File: tb/tb_parking_sensor_encoder.sv
// Randomized and directed bench for parking_sensor_encoder against
// a transaction-level reference model.
module tb_parking_sensor_encoder;

  localparam int DB = 4;
  localparam int TO = 8;
`ifdef PARKING_ENC_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  parking_sensor_encoder_if bus();

  parking_sensor_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int first_iss = -1;
  int first_drop = -1;
  int issued[$];
  logic [3:0] prev_cmd = 4'b0000;

  // Reference model: index 4 is the entry gate, 0..3 are spots.
  int m_cnt[5];
  bit m_lvl[5];
  bit m_lvl_q[5];
  bit m_pend[5];
  int m_srv;
  bit m_iss;
  int m_wait;
  int m_tries;
  bit m_exit_next;
  bit m_drop;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 5; i++) begin
      m_cnt[i]   = 0;
      m_lvl[i]   = 1'b0;
      m_lvl_q[i] = 1'b0;
      m_pend[i]  = 1'b0;
    end
    m_srv       = -1;
    m_iss       = 1'b0;
    m_wait      = 0;
    m_tries     = 0;
    m_exit_next = 1'b1;
    m_drop      = 1'b0;
  endfunction

  function automatic logic [4:0] m_pvec();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [3:0] m_cmd();
    if (m_srv < 0 || !m_iss) return 4'b0000;
    if (m_srv == 4) return 4'b1000;
    return 4'(4 + m_srv);
  endfunction

  function automatic void m_step(logic [4:0] r, bit ack);
    int clr;
    int pick;
    bit drop;
    bit rise[5];
    clr  = -1;
    drop = 1'b0;
    for (int i = 0; i < 5; i++) rise[i] = m_lvl[i] && !m_lvl_q[i];
    if (m_srv < 0) begin
      pick = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i]) pick = i;
      if (m_pend[4] && (pick < 0 || !m_exit_next)) pick = 4;
      if (pick >= 0) begin
        m_srv       = pick;
        m_iss       = 1'b1;
        m_tries     = 0;
        m_exit_next = (pick == 4);
      end
    end else if (m_iss) begin
      m_iss  = 1'b0;
      m_wait = 0;
    end else if (ack) begin
      clr   = m_srv;
      m_srv = -1;
    end else if (m_wait + 1 >= TO) begin
      if (RETRY && m_tries == 0) begin
        m_tries = 1;
        m_iss   = 1'b1;
      end else begin
        clr   = m_srv;
        m_srv = -1;
        drop  = 1'b1;
      end
    end else begin
      m_wait++;
    end
    m_drop = drop;
    for (int i = 0; i < 5; i++)
      m_pend[i] = (m_pend[i] && i != clr) || rise[i];
    for (int i = 0; i < 5; i++) begin
      m_lvl_q[i] = m_lvl[i];
      if (r[i] == m_lvl[i]) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] + 1 >= DB) begin
        m_lvl[i] = r[i];
        m_cnt[i] = 0;
      end else begin
        m_cnt[i]++;
      end
    end
  endfunction

  // Called at a falling edge; ends at the next falling edge.
  // ack_mode: 0 never, 1 first wait cycle, 2 random.
  task automatic run_cycle(logic [4:0] r, int ack_mode);
    bit ack;
    case (ack_mode)
      1: ack = (m_srv >= 0) && !m_iss && (m_wait == 0);
      2: ack = ($urandom_range(0, 3) == 0);
      default: ack = 1'b0;
    endcase
    bus.enter_raw       = r[4];
    bus.leave_raw       = r[3:0];
    bus.door_open_pulse = ack;
    @(posedge clk);
    m_step(r, ack);
    @(negedge clk);
    cyc++;
    chk("cmd", bus.cmd, m_cmd());
    chk("busy", bus.busy, m_srv >= 0);
    chk("drop_err", bus.drop_err, m_drop);
    chk("pending", bus.pending, m_pvec());
    chk("cmd_b2b", (prev_cmd != 0) && (bus.cmd != 0), 0);
    if (bus.cmd != 0) begin
      issued.push_back(int'(bus.cmd));
      if (first_iss < 0) first_iss = cyc;
    end
    if (bus.drop_err && first_drop < 0) first_drop = cyc;
    prev_cmd = bus.cmd;
  endtask

  task automatic do_reset(logic [4:0] r);
    bus.enter_raw       = r[4];
    bus.leave_raw       = r[3:0];
    bus.door_open_pulse = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_cmd", bus.cmd, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_drop", bus.drop_err, 0);
    chk("rst_pend", bus.pending, 0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    issued.delete();
    first_iss  = -1;
    first_drop = -1;
    prev_cmd   = 4'b0000;
  endtask

  initial begin
    int k;
    int n;
    logic [4:0] rr;
    reset               = 1'b1;
    bus.enter_raw       = 1'b0;
    bus.leave_raw       = 4'b0000;
    bus.door_open_pulse = 1'b0;
    m_reset();
    @(negedge clk);
    do_reset(5'b00000);
    repeat (3) run_cycle(5'b00000, 2);

    // Bouncy entry sensor then stable high.
    run_cycle(5'b10000, 1);
    run_cycle(5'b00000, 1);
    k = cyc;
    run_cycle(5'b10000, 1);
    repeat (14) run_cycle(5'b10000, 1);
    chk("s030_count", issued.size(), 1);
    chk("s030_delay", first_iss - k, DB + 2);

    // Two spots rising together, lowest first.
    do_reset(5'b00000);
    repeat (20) run_cycle(5'b01010, 1);
    chk("s031_count", issued.size(), 2);
    chk("s031_first", issued.size() > 0 ? issued[0] : 0, 4'b0101);
    chk("s031_second", issued.size() > 1 ? issued[1] : 0, 4'b0111);
    chk("s031_pend", bus.pending, 5'b00000);

    // Enter and spot 2 together: exit class first after reset.
    do_reset(5'b00000);
    repeat (20) run_cycle(5'b10100, 1);
    chk("s032_count", issued.size(), 2);
    chk("s032_first", issued.size() > 0 ? issued[0] : 0, 4'b0110);
    chk("s032_second", issued.size() > 1 ? issued[1] : 0, 4'b1000);

    // No acknowledge at all.
    do_reset(5'b00000);
    repeat (35) run_cycle(5'b10000, 0);
    chk("s033_count", issued.size(), RETRY ? 2 : 1);
    chk("s033_drop_at", first_drop - first_iss, RETRY ? 18 : 9);
    chk("s033_pend", bus.pending, 5'b00000);

    // Reset while waiting for an ack.
    do_reset(5'b00000);
    n = 0;
    do begin
      run_cycle(5'b10001, 0);
      n++;
    end while (!(bus.busy && bus.cmd == 0) && n < 20);
    chk("s034_in_wait", bus.busy && bus.cmd == 0, 1);
    chk("s034_pend", bus.pending, 5'b10001);
    chk("s034_first", issued.size() > 0 ? issued[0] : 0, 4'b0100);
    do_reset(5'b10000);
    repeat (14) run_cycle(5'b10000, 1);
    chk("s034_reissue", issued.size(), 1);
    chk("s034_cmd", issued.size() > 0 ? issued[0] : 0, 4'b1000);

    // Random sensor activity with random acks and occasional resets.
    do_reset(5'b00000);
    rr = 5'b00000;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 11) == 0) rr[i] = ~rr[i];
      if ($urandom_range(0, 599) == 0) do_reset(rr);
      else run_cycle(rr, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
